// File: rtl/div_seq_ctrl_pkg.sv
// Shared constants, state encoding and decode helper for the E-stage divide sequencer.
package div_seq_ctrl_pkg;

  localparam logic [4:0]  DIV_CONTROL  = 5'b11010;
  localparam logic [4:0]  DIVU_CONTROL = 5'b11011;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  localparam int DIV_TIMEOUT = 40;
  localparam int DIV_CNT_W   = 6;

  typedef enum logic [1:0] {
    DIVS_IDLE = 2'd0,
    DIVS_BUSY = 2'd1,
    DIVS_DONE = 2'd2,
    DIVS_HOLD = 2'd3
  } divs_state_e;

  function automatic logic is_div_op(input logic en, input logic [4:0] ctrl);
    return en & ((ctrl == DIV_CONTROL) | (ctrl == DIVU_CONTROL));
  endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Signal bundle between the divide sequencer, the E-stage pipeline, the divider and HI/LO.
interface div_seq_ctrl_if;

  logic        en_i;
  logic [4:0]  alucontrol_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        ext_stall_i;
  logic        div_ready_i;
  logic [63:0] div_result_i;

  logic        div_start_o;
  logic        div_signed_o;
  logic [31:0] div_a_o;
  logic [31:0] div_b_o;
  logic        div_annul_o;
  logic        stall_o;
  logic        hilo_we_o;
  logic [63:0] hilo_o;
  logic        timeout_o;

  modport slave (
    input  en_i, alucontrol_i, a_i, b_i, flush_i, ext_stall_i, div_ready_i, div_result_i,
    output div_start_o, div_signed_o, div_a_o, div_b_o, div_annul_o, stall_o,
           hilo_we_o, hilo_o, timeout_o
  );

  modport master (
    output en_i, alucontrol_i, a_i, b_i, flush_i, ext_stall_i, div_ready_i, div_result_i,
    input  div_start_o, div_signed_o, div_a_o, div_b_o, div_annul_o, stall_o,
           hilo_we_o, hilo_o, timeout_o
  );

endinterface

// File: rtl/div_seq_ctrl.sv
// E-stage DIV/DIVU sequencer: latches operands, holds the divider start, stalls the pipe
// and issues a single HI/LO write, with flush, divide-by-zero and watchdog abort handling.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DIV_TIMEOUT,
  parameter int CNT_W   = DIV_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  div_seq_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  divs_state_e      r_state;
  divs_state_e      w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_signed;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [63:0]      r_hilo;

  logic w_is_div;
  logic w_accept;
  logic w_capture;
  logic w_stall;
  logic w_start;
  logic w_annul;
  logic w_timeout;
  logic w_hilo_we;

  assign w_is_div = is_div_op(bus.en_i, bus.alucontrol_i);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_stall      = 1'b0;
    w_start      = 1'b0;
    w_annul      = 1'b0;
    w_timeout    = 1'b0;
    w_hilo_we    = 1'b0;
    case (r_state)
      DIVS_IDLE: begin
        // A zero divisor never starts the divider; HOLD blocks re-issue while E is frozen.
        if (w_is_div && !bus.flush_i) begin
          w_stall = 1'b1;
          if (bus.b_i == ZERO_WORD) begin
            w_state_next = DIVS_HOLD;
          end else begin
            w_accept     = 1'b1;
            w_state_next = DIVS_BUSY;
          end
        end
      end
      DIVS_BUSY: begin
        w_start = 1'b1;
        w_stall = 1'b1;
        if (bus.flush_i) begin
          w_annul      = 1'b1;
          w_state_next = DIVS_IDLE;
        end else if (bus.div_ready_i) begin
          w_capture    = 1'b1;
          w_state_next = DIVS_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_annul      = 1'b1;
          w_timeout    = 1'b1;
          w_state_next = DIVS_IDLE;
        end
      end
      DIVS_DONE: begin
        w_hilo_we    = !bus.flush_i;
        w_state_next = bus.ext_stall_i ? DIVS_HOLD : DIVS_IDLE;
      end
      DIVS_HOLD: begin
        if (!bus.ext_stall_i || bus.flush_i) begin
          w_state_next = DIVS_IDLE;
        end
      end
      default: w_state_next = DIVS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= DIVS_IDLE;
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_hilo   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a      <= bus.a_i;
        r_b      <= bus.b_i;
        r_signed <= (bus.alucontrol_i == DIV_CONTROL);
        r_cnt    <= '0;
      end else if (r_state == DIVS_BUSY && r_cnt != CNT_SAT) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (w_capture) begin
        r_hilo <= bus.div_result_i;
      end
    end
  end

  assign bus.div_start_o  = w_start;
  assign bus.div_signed_o = r_signed;
  assign bus.div_a_o      = r_a;
  assign bus.div_b_o      = r_b;
  assign bus.div_annul_o  = w_annul;
  assign bus.stall_o      = w_stall;
  assign bus.hilo_we_o    = w_hilo_we;
  assign bus.hilo_o       = r_hilo;
  assign bus.timeout_o    = w_timeout;

endmodule
